// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared sizes, types and the collector state encoding for
// clients of the 8-lane register bank.
package reg_bank_pkg;

  localparam int NUM_LANES = 8;
  localparam int NUM_REGS  = 16;
  localparam int ADDR_W    = $clog2(NUM_REGS);
  localparam int DATA_W    = 64;
  localparam int TAG_W     = 6;

  typedef logic [NUM_LANES-1:0] lane_mask_t;
  typedef logic [ADDR_W-1:0]    reg_addr_t;
  typedef logic [DATA_W-1:0]    lane_data_t;
  typedef logic [TAG_W-1:0]     tag_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_AB,
    RD_C,
    HOLD
  } opc_state_t;

  // Lanes that actually read for one operand: the request mask, gated by
  // whether that operand is needed at all.
  function automatic lane_mask_t lane_enables(input lane_mask_t mask, input logic needed);
    return mask & {NUM_LANES{needed}};
  endfunction

endpackage

// File: rtl/opc_lane_capture.sv
// opc_lane_capture: one lane of one operand. Loads on a capture cycle,
// forcing zero for lanes that are not read, and optionally taking the
// snooped write data instead of the bank read data.
module opc_lane_capture
  import reg_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              lane_en,
  input  logic              bypass_hit,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] q
);

  // Operand register: updated only on capture cycles so held values survive
  // later bank writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      if (!lane_en) begin
        q <= '0;
      end else if (bypass_hit) begin
        q <= wb_data;
      end else begin
        q <= rdata;
      end
    end
  end

endmodule

// File: rtl/reg_operand_collector.sv
// reg_operand_collector: accepts an operand-fetch request, reads A/B on the
// two bank ports, optionally reads C on port 0 in a second cycle, and holds
// the per-lane operands until the consumer takes them.
// Build macro REG_OPC_WB_BYPASS_EN: when defined, a bank write landing on the
// same edge as a capture, to the address being read, is forwarded per lane.
module reg_operand_collector
  import reg_bank_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [TAG_W-1:0]            req_tag,
  input  logic [NUM_LANES-1:0]        req_mask,
  input  logic [2:0]                  req_use,
  input  logic [ADDR_W-1:0]           req_ra,
  input  logic [ADDR_W-1:0]           req_rb,
  input  logic [ADDR_W-1:0]           req_rc,
  output logic [NUM_LANES-1:0]        read_en_0,
  output logic [NUM_LANES-1:0]        read_en_1,
  output logic [ADDR_W-1:0]           raddr_0,
  output logic [ADDR_W-1:0]           raddr_1,
  input  logic [NUM_LANES*DATA_W-1:0] rdata_0,
  input  logic [NUM_LANES*DATA_W-1:0] rdata_1,
  input  logic [NUM_LANES-1:0]        wb_en,
  input  logic [ADDR_W-1:0]           wb_addr,
  input  logic [NUM_LANES*DATA_W-1:0] wb_data,
  output logic                        op_valid,
  input  logic                        op_ready,
  output logic [TAG_W-1:0]            op_tag,
  output logic [NUM_LANES-1:0]        op_mask,
  output logic [NUM_LANES*DATA_W-1:0] op_a,
  output logic [NUM_LANES*DATA_W-1:0] op_b,
  output logic [NUM_LANES*DATA_W-1:0] op_c
);

  opc_state_t state_reg, state_next;

  tag_t       tag_reg;
  lane_mask_t mask_reg;
  logic [2:0] use_reg;
  reg_addr_t  ra_reg, rb_reg, rc_reg;

  logic       accept;
  logic       op_valid_reg;
  tag_t       op_tag_reg;
  lane_mask_t op_mask_reg;

  logic       load_ab, load_c, c_phase;
  lane_mask_t en_a, en_b, en_c;
  lane_mask_t hit_a, hit_b, hit_c;

  // Next state, request handshake and bank port drive.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    read_en_0  = '0;
    read_en_1  = '0;
    raddr_0    = '0;
    raddr_1    = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = RD_AB;
      end
      RD_AB: begin
        read_en_0  = lane_enables(mask_reg, use_reg[0]);
        raddr_0    = ra_reg;
        read_en_1  = lane_enables(mask_reg, use_reg[1]);
        raddr_1    = rb_reg;
        state_next = use_reg[2] ? RD_C : HOLD;
      end
      RD_C: begin
        read_en_0  = mask_reg;
        raddr_0    = rc_reg;
        state_next = HOLD;
      end
      HOLD: begin
        req_ready = op_ready;
        if (op_ready) state_next = req_valid ? RD_AB : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Latch the request fields on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg  <= '0;
      mask_reg <= '0;
      use_reg  <= '0;
      ra_reg   <= '0;
      rb_reg   <= '0;
      rc_reg   <= '0;
    end else if (accept) begin
      tag_reg  <= req_tag;
      mask_reg <= req_mask;
      use_reg  <= req_use;
      ra_reg   <= req_ra;
      rb_reg   <= req_rb;
      rc_reg   <= req_rc;
    end
  end

  // Output-side valid, tag and mask; tag/mask move with the A/B capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid_reg <= 1'b0;
      op_tag_reg   <= '0;
      op_mask_reg  <= '0;
    end else begin
      op_valid_reg <= (state_next == HOLD);
      if (state_reg == RD_AB) begin
        op_tag_reg  <= tag_reg;
        op_mask_reg <= mask_reg;
      end
    end
  end

  assign op_valid = op_valid_reg;
  assign op_tag   = op_tag_reg;
  assign op_mask  = op_mask_reg;

  // C is cleared on the A/B cycle so requests without C present zero.
  assign load_ab = (state_reg == RD_AB);
  assign c_phase = (state_reg == RD_C);
  assign load_c  = load_ab || c_phase;
  assign en_a    = lane_enables(mask_reg, use_reg[0]);
  assign en_b    = lane_enables(mask_reg, use_reg[1]);
  assign en_c    = lane_enables(mask_reg, c_phase);

`ifdef REG_OPC_WB_BYPASS_EN
  assign hit_a = wb_en & {NUM_LANES{wb_addr == ra_reg}};
  assign hit_b = wb_en & {NUM_LANES{wb_addr == rb_reg}};
  assign hit_c = wb_en & {NUM_LANES{wb_addr == rc_reg}};
`else
  // Snoop ports exist but are ignored; only the bank data is captured.
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_addr};
  assign hit_a = '0;
  assign hit_b = '0;
  assign hit_c = '0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      opc_lane_capture u_cap_a (
        .clk        (clk),
        .rst        (rst),
        .load       (load_ab),
        .lane_en    (en_a[gi]),
        .bypass_hit (hit_a[gi]),
        .rdata      (rdata_0[gi*DATA_W +: DATA_W]),
        .wb_data    (wb_data[gi*DATA_W +: DATA_W]),
        .q          (op_a[gi*DATA_W +: DATA_W])
      );
      opc_lane_capture u_cap_b (
        .clk        (clk),
        .rst        (rst),
        .load       (load_ab),
        .lane_en    (en_b[gi]),
        .bypass_hit (hit_b[gi]),
        .rdata      (rdata_1[gi*DATA_W +: DATA_W]),
        .wb_data    (wb_data[gi*DATA_W +: DATA_W]),
        .q          (op_b[gi*DATA_W +: DATA_W])
      );
      opc_lane_capture u_cap_c (
        .clk        (clk),
        .rst        (rst),
        .load       (load_c),
        .lane_en    (en_c[gi]),
        .bypass_hit (hit_c[gi]),
        .rdata      (rdata_0[gi*DATA_W +: DATA_W]),
        .wb_data    (wb_data[gi*DATA_W +: DATA_W]),
        .q          (op_c[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_reg_operand_collector.sv
// tb_reg_operand_collector: directed and random operand fetches against a
// behavioural register bank; expected operands come from the bank contents
// and the request fields.
module tb_reg_operand_collector;
  import reg_bank_pkg::*;

  localparam int W = NUM_LANES * DATA_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [TAG_W-1:0]     req_tag = '0;
  logic [NUM_LANES-1:0] req_mask = '0;
  logic [2:0]           req_use = '0;
  logic [ADDR_W-1:0]    req_ra = '0, req_rb = '0, req_rc = '0;
  logic [NUM_LANES-1:0] read_en_0, read_en_1;
  logic [ADDR_W-1:0]    raddr_0, raddr_1;
  logic [W-1:0]         rdata_0, rdata_1;
  logic [NUM_LANES-1:0] wb_en = '0;
  logic [ADDR_W-1:0]    wb_addr = '0;
  logic [W-1:0]         wb_data = '0;
  logic                 op_valid;
  logic                 op_ready = 1'b0;
  logic [TAG_W-1:0]     op_tag;
  logic [NUM_LANES-1:0] op_mask;
  logic [W-1:0]         op_a, op_b, op_c;

  logic [DATA_W-1:0] bank [NUM_REGS][NUM_LANES];

  int compared = 0;
  int mismatched = 0;

  logic [TAG_W-1:0]     exp_tag;
  logic [NUM_LANES-1:0] exp_mask;
  logic [2:0]           exp_use;
  logic [ADDR_W-1:0]    exp_ra, exp_rb, exp_rc;
  logic [W-1:0]         exp_a, exp_b, exp_c;
  logic [W-1:0]         held_a, held_b;

  reg_operand_collector dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_mask(req_mask), .req_use(req_use),
    .req_ra(req_ra), .req_rb(req_rb), .req_rc(req_rc),
    .read_en_0(read_en_0), .read_en_1(read_en_1),
    .raddr_0(raddr_0), .raddr_1(raddr_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .op_valid(op_valid), .op_ready(op_ready), .op_tag(op_tag),
    .op_mask(op_mask), .op_a(op_a), .op_b(op_b), .op_c(op_c)
  );

  always #5 clk = ~clk;

  // Bank read ports: combinational, data returned regardless of enable so
  // that lane gating must happen in the collector.
  always_comb begin
    rdata_0 = '0;
    rdata_1 = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      rdata_0[l*DATA_W +: DATA_W] = bank[raddr_0][l];
      rdata_1[l*DATA_W +: DATA_W] = bank[raddr_1][l];
    end
  end

  // Bank write port.
  always @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++)
      if (wb_en[l]) bank[wb_addr][l] <= wb_data[l*DATA_W +: DATA_W];
  end

  function automatic logic [DATA_W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Expected operand: each enabled lane holds the register, others zero.
  function automatic logic [W-1:0] model_opnd(input logic [ADDR_W-1:0] r, input logic [NUM_LANES-1:0] en);
    logic [W-1:0] res;
    res = '0;
    for (int l = 0; l < NUM_LANES; l++)
      if (en[l]) res[l*DATA_W +: DATA_W] = bank[r][l];
    return res;
  endfunction

  task automatic check(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", name, obs, exp);
    end
  endtask

  task automatic bank_write(input logic [ADDR_W-1:0] r, input logic [NUM_LANES-1:0] en);
    wb_en   = en;
    wb_addr = r;
    for (int l = 0; l < NUM_LANES; l++)
      wb_data[l*DATA_W +: DATA_W] = (r == 3) ? 64'h1111_0000 + l :
                                    (r == 5) ? 64'h2222_0000 + l : rnd64();
    @(posedge clk); #1;
    wb_en = '0;
  endtask

  task automatic issue(input logic [TAG_W-1:0] tag, input logic [NUM_LANES-1:0] mask,
                       input logic [2:0] u, input logic [ADDR_W-1:0] ra,
                       input logic [ADDR_W-1:0] rb, input logic [ADDR_W-1:0] rc);
    req_valid = 1'b1;
    req_tag = tag; req_mask = mask; req_use = u;
    req_ra = ra; req_rb = rb; req_rc = rc;
    exp_tag = tag; exp_mask = mask; exp_use = u;
    exp_ra = ra; exp_rb = rb; exp_rc = rc;
    exp_a = model_opnd(ra, u[0] ? mask : '0);
    exp_b = model_opnd(rb, u[1] ? mask : '0);
    exp_c = model_opnd(rc, u[2] ? mask : '0);
  endtask

  // Accept the pending request and follow it to HOLD, checking port drive
  // and latency on the way. Optionally writes lanes 0/7 of ra during RD_AB.
  task automatic run_req(input bit wb_ab);
    #1;
    check("req_ready_at_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    op_ready  = 1'b0;
    check("rdab_read_en_0", read_en_0, exp_use[0] ? exp_mask : '0);
    check("rdab_raddr_0", raddr_0, exp_ra);
    check("rdab_read_en_1", read_en_1, exp_use[1] ? exp_mask : '0);
    check("rdab_raddr_1", raddr_1, exp_rb);
    check("rdab_op_valid", op_valid, 0);
    if (wb_ab) begin
      wb_en   = 8'h81;
      wb_addr = exp_ra;
      for (int l = 0; l < NUM_LANES; l++) wb_data[l*DATA_W +: DATA_W] = 64'hDEAD_BEEF;
    end
    if (exp_use[2]) begin
      @(posedge clk); #1;
      wb_en = '0;
      check("rdc_read_en_0", read_en_0, exp_mask);
      check("rdc_raddr_0", raddr_0, exp_rc);
      check("rdc_read_en_1", read_en_1, 0);
      check("rdc_op_valid", op_valid, 0);
    end
    @(posedge clk); #1;
    wb_en = '0;
    check("hold_op_valid", op_valid, 1);
    check("hold_op_tag", op_tag, exp_tag);
    check("hold_op_mask", op_mask, exp_mask);
    check("hold_op_a", op_a, exp_a);
    check("hold_op_b", op_b, exp_b);
    check("hold_op_c", op_c, exp_c);
  endtask

  task automatic release_hold();
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    check("after_release_op_valid", op_valid, 0);
    check("after_release_req_ready", req_ready, 1);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_op_valid", op_valid, 0);
    check("reset_req_ready", req_ready, 1);
    check("reset_read_en", {read_en_1, read_en_0}, 0);
    check("reset_raddr", {raddr_1, raddr_0}, 0);
    check("reset_ops", op_a | op_b | op_c, 0);
    check("reset_tag_mask", {op_tag, op_mask}, 0);

    for (int r = 0; r < NUM_REGS; r++) begin
      logic [ADDR_W-1:0] ra;
      ra = r[ADDR_W-1:0];
      bank_write(ra, '1);
    end

    // A+B fetch.
    issue(6'h2A, 8'hFF, 3'b011, 4'd3, 4'd5, 4'd0);
    run_req(0);
    release_hold();

    // Three operands.
    issue(6'h11, 8'hFF, 3'b111, 4'd1, 4'd2, 4'd15);
    run_req(0);
    release_hold();

    // Partial mask.
    issue(6'h05, 8'h0F, 3'b111, 4'd3, 4'd5, 4'd15);
    run_req(0);
    release_hold();

    // No operands used.
    issue(6'h3F, 8'hFF, 3'b000, 4'd3, 4'd5, 4'd15);
    run_req(0);
    release_hold();

    // Backpressure with a waiting request and a bank write during HOLD.
    issue(6'h01, 8'hFF, 3'b011, 4'd6, 4'd7, 4'd0);
    run_req(0);
    held_a = exp_a;
    held_b = exp_b;
    issue(6'h02, 8'hFF, 3'b111, 4'd8, 4'd9, 4'd10);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        wb_en = '1;
        wb_addr = 4'd6;
        for (int l = 0; l < NUM_LANES; l++) wb_data[l*DATA_W +: DATA_W] = rnd64();
      end
      @(posedge clk); #1;
      wb_en = '0;
      check("stall_op_valid", op_valid, 1);
      check("stall_op_a", op_a, held_a);
      check("stall_op_b", op_b, held_b);
      check("stall_op_tag", op_tag, 6'h01);
      check("stall_req_ready", req_ready, 0);
    end
    op_ready = 1'b1;
    run_req(0);
    release_hold();

    // Same-cycle write during RD_AB, A and B both reading r6.
    issue(6'h15, 8'hFF, 3'b011, 4'd6, 4'd6, 4'd0);
`ifdef REG_OPC_WB_BYPASS_EN
    exp_a[0 +: DATA_W] = 64'hDEAD_BEEF;
    exp_a[7*DATA_W +: DATA_W] = 64'hDEAD_BEEF;
    exp_b[0 +: DATA_W] = 64'hDEAD_BEEF;
    exp_b[7*DATA_W +: DATA_W] = 64'hDEAD_BEEF;
`endif
    run_req(1);
    release_hold();
    issue(6'h16, 8'hFF, 3'b001, 4'd6, 4'd0, 4'd0);
    run_req(0);
    check("bypass_written_lane0", op_a[0 +: DATA_W], 64'hDEAD_BEEF);
    release_hold();

    // Reset asserted during RD_AB drops the request.
    issue(6'h33, 8'hFF, 3'b111, 4'd3, 4'd5, 4'd1);
    #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_op_valid", op_valid, 0);
    check("midrst_read_en", {read_en_1, read_en_0}, 0);
    check("midrst_raddr", {raddr_1, raddr_0}, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_ops", op_a | op_b | op_c, 0);
    check("midrst_tag_mask", {op_tag, op_mask}, 0);
    @(posedge clk); #1;
    check("midrst_dropped", op_valid, 0);

    // Random requests with random stalls and idle bank writes.
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [ADDR_W-1:0] wr;
        logic [NUM_LANES-1:0] we;
        wr = ADDR_W'($urandom_range(0, NUM_REGS - 1));
        we = NUM_LANES'($urandom);
        bank_write(wr, we);
      end
      issue(TAG_W'($urandom), NUM_LANES'($urandom), 3'($urandom),
            ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom));
      run_req(0);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        @(posedge clk); #1;
        check("rand_stall_op_a", op_a, exp_a);
      end
      release_hold();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
